writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 2, the number of long-latency result entries buffered (power of two, 2..8).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 3, the number of consecutive blocked cycles before the FIFO head is forced.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the only clock; every flop SHALL update on the rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port pipe_we_i, input, 1 bit, the in-order pipeline write request.
REQ-006 The block SHALL have port pipe_rd_i, input, `REG_NUM_BITS, the pipeline destination register.
REQ-007 The block SHALL have port pipe_data_i, input, `REG_LEN, the pipeline write data.
REQ-008 The block SHALL have port pipe_stall_o, output, 1 bit, which tells the pipeline to hold its write this cycle.
REQ-009 The block SHALL have port issue_i, input, 1 bit, which marks issue of a long-latency op.
REQ-010 The block SHALL have port issue_rd_i, input, `REG_NUM_BITS, the destination of the issued op.
REQ-011 The block SHALL have port lu_valid_i, input, 1 bit, the long-latency result valid.
REQ-012 The block SHALL have port lu_ready_o, output, 1 bit, the FIFO-accept signal for long-latency results.
REQ-013 The block SHALL have port lu_rd_i, input, `REG_NUM_BITS, the long-latency result destination.
REQ-014 The block SHALL have port lu_data_i, input, `REG_LEN, the long-latency result data.
REQ-015 The block SHALL have port RegWrite_o, output, 1 bit, the register-file write enable.
REQ-016 The block SHALL have port RDaddr_o, output, `REG_NUM_BITS, the register-file write address.
REQ-017 The block SHALL have port RDdata_o, output, `REG_LEN, the register-file write data.
REQ-018 The block SHALL have port busy_o, output, 32 bits, the pending-write scoreboard with bit n set for register xn.

Function
REQ-019 A long-latency result SHALL be accepted when lu_valid_i and lu_ready_o are both high at a rising edge, and lu_ready_o SHALL equal (FIFO count < FIFO_DEPTH), driven from registered state only.
REQ-020 A pipeline write SHALL be "effective" when pipe_we_i=1 and pipe_rd_i!=0; a pipeline write to x0 SHALL be dropped and never drive RegWrite_o.
REQ-021 Arbitration SHALL use per-cycle priority: when the starve counter is below STARVE_LIMIT, an effective pipeline write wins and the FIFO head waits; when there is no effective pipeline write, the FIFO head (if any) commits.
REQ-022 When the starve counter equals STARVE_LIMIT and the FIFO is non-empty, the FIFO head SHALL commit, pipe_stall_o SHALL be 1 (combinational), and the pipeline write SHALL not be taken that cycle.
REQ-023 pipe_stall_o SHALL be 0 in every other case.
REQ-024 The starve counter SHALL increment (saturating at STARVE_LIMIT) in each cycle the FIFO is non-empty and the head is blocked, and SHALL clear to 0 in each cycle the head commits or the FIFO is empty.
REQ-025 A winning write SHALL appear on RegWrite_o/RDaddr_o/RDdata_o registered one cycle after the decision edge, for a latency of 1.
REQ-026 RegWrite_o SHALL be 0 in cycles with no commit, and RDaddr_o/RDdata_o SHALL then hold their previous values.
REQ-027 The FIFO SHALL commit results in arrival order, its pointers SHALL wrap modulo FIFO_DEPTH, and an accept and a commit in the same cycle on a full FIFO SHALL be impossible because ready is low when full.
REQ-028 Simultaneous accept and commit on a non-full, non-empty FIFO SHALL leave the count unchanged.
REQ-029 A long-latency result with lu_rd_i=0 SHALL be accepted, occupy a slot, and commit with RegWrite_o=0.
REQ-030 issue_i with issue_rd_i!=0 SHALL set busy bit issue_rd_i at the edge, and a FIFO-head commit SHALL clear the busy bit of its destination.
REQ-031 When a set and a clear of the same busy bit occur in the same cycle, the set SHALL win.
REQ-032 busy_o[0] SHALL always be 0.
REQ-033 busy_o SHALL be registered, and pipeline writes SHALL never alter busy_o.

Reset
REQ-034 When rst_i=1 at a rising edge: FIFO SHALL empty, the starve counter SHALL clear to 0, busy_o SHALL clear to 0, RegWrite_o, RDaddr_o and RDdata_o SHALL clear to 0, and any beat offered that cycle SHALL be discarded.
REQ-035 After reset, lu_ready_o SHALL be 1 and pipe_stall_o SHALL be 0.
REQ-036 Reset asserted mid-drain SHALL drop all buffered results without a write.

Verification
REQ-037 Scenario: pipe write x5=0x11 with FIFO empty -> next cycle RegWrite_o=1, RDaddr_o=5, RDdata_o=0x11.
REQ-038 Scenario: issue x7, then LU result x7=0xAB with no pipe write -> accepted, written one cycle later, busy_o[7] 1 then 0.
REQ-039 Scenario: continuous pipe writes with 1 FIFO entry and STARVE_LIMIT=3 -> 3 pipe writes commit, then pipe_stall_o=1 for one cycle while the FIFO head commits.
REQ-040 Scenario: 2 LU results and no drain -> lu_ready_o=0, and a third lu_valid_i is held off.
REQ-041 Scenario: issue x3 in the same cycle as commit of the older x3 result -> busy_o[3] stays 1.
REQ-042 Scenario: pipe write to x0 plus LU write to x0 -> RegWrite_o never 1, and busy_o stays 0.
REQ-043 Scenario: rst_i with 2 FIFO entries -> no writes emitted, lu_ready_o=1 next cycle.

Source files
------------

// File: rtl/writeback_arbiter.sv
// ---------------------------------------------------------------------------
// writeback_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   and a small FIFO of long-latency (LU) results. The pipeline normally has
//   priority. A starve counter bounds how long the FIFO head can be blocked:
//   once it reaches STARVE_LIMIT, the head is forced through and the pipeline
//   is stalled for that cycle. A 32-bit scoreboard tracks the registers that
//   still have an outstanding long-latency write.
//
// Ports
//   clk_i, rst_i           : clock, synchronous active-high reset
//   pipe_we_i/rd_i/data_i  : pipeline write request
//   pipe_stall_o           : pipeline must hold its write this cycle
//   issue_i/issue_rd_i     : a long-latency op was issued to issue_rd_i
//   lu_valid_i/rd_i/data_i : long-latency result beat
//   lu_ready_o             : FIFO can accept a result beat
//   RegWrite_o/RDaddr_o/RDdata_o : registered register-file write
//   busy_o                 : pending long-latency write scoreboard (bit n = xn)
// ---------------------------------------------------------------------------
`ifndef REG_NUM_BITS
`define REG_NUM_BITS 5
`endif
`ifndef REG_LEN
`define REG_LEN 32
`endif

module writeback_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     pipe_we_i,
  input  logic [`REG_NUM_BITS-1:0] pipe_rd_i,
  input  logic [`REG_LEN-1:0]      pipe_data_i,
  output logic                     pipe_stall_o,
  input  logic                     issue_i,
  input  logic [`REG_NUM_BITS-1:0] issue_rd_i,
  input  logic                     lu_valid_i,
  output logic                     lu_ready_o,
  input  logic [`REG_NUM_BITS-1:0] lu_rd_i,
  input  logic [`REG_LEN-1:0]      lu_data_i,
  output logic                     RegWrite_o,
  output logic [`REG_NUM_BITS-1:0] RDaddr_o,
  output logic [`REG_LEN-1:0]      RDdata_o,
  output logic [31:0]              busy_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_LIMIT);

  // FIFO storage (no reset needed: pointers/count define validity)
  logic [`REG_NUM_BITS-1:0] fifo_rd_q   [FIFO_DEPTH];
  logic [`REG_LEN-1:0]      fifo_data_q [FIFO_DEPTH];

  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [STV_W-1:0]         starve_q, starve_d;
  logic [31:0]              busy_q, busy_d;
  logic                     regwrite_q, regwrite_d;
  logic [`REG_NUM_BITS-1:0] rdaddr_q, rdaddr_d;
  logic [`REG_LEN-1:0]      rddata_q, rddata_d;

  logic                     fifo_empty_s;
  logic                     accept_s;
  logic                     pipe_eff_s;
  logic                     force_s;
  logic                     head_commit_s;
  logic                     pipe_commit_s;
  logic [`REG_NUM_BITS-1:0] head_rd_s;
  logic [`REG_LEN-1:0]      head_data_s;

  assign fifo_empty_s  = (count_q == {CNT_W{1'b0}});
  assign lu_ready_o    = (count_q < DEPTH_C);
  assign accept_s      = lu_valid_i && lu_ready_o;
  assign pipe_eff_s    = pipe_we_i && (pipe_rd_i != {`REG_NUM_BITS{1'b0}});
  // Starved head is forced through; the pipeline is told to hold.
  assign force_s       = (starve_q == STARVE_C) && !fifo_empty_s;
  assign head_commit_s = !fifo_empty_s && (force_s || !pipe_eff_s);
  assign pipe_commit_s = pipe_eff_s && !force_s;
  assign pipe_stall_o  = force_s;
  assign head_rd_s     = fifo_rd_q[rd_ptr_q];
  assign head_data_s   = fifo_data_q[rd_ptr_q];

  assign RegWrite_o    = regwrite_q;
  assign RDaddr_o      = rdaddr_q;
  assign RDdata_o      = rddata_q;
  assign busy_o        = busy_q;

  // Next-state for FIFO pointers, occupancy and starve counter
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (head_commit_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({accept_s, head_commit_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (fifo_empty_s || head_commit_s) begin
      starve_d = {STV_W{1'b0}};
    end else if (starve_q != STARVE_C) begin
      starve_d = starve_q + STV_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Next-state for the register-file write port and the busy scoreboard
  always_comb begin
    regwrite_d = 1'b0;
    rdaddr_d   = rdaddr_q;
    rddata_d   = rddata_q;
    busy_d     = busy_q;
    if (head_commit_s) begin
      // A head destined for x0 still retires, but writes nothing.
      if (head_rd_s != {`REG_NUM_BITS{1'b0}}) begin
        regwrite_d        = 1'b1;
        rdaddr_d          = head_rd_s;
        rddata_d          = head_data_s;
        busy_d[head_rd_s] = 1'b0;
      end else begin
        regwrite_d = 1'b0;
      end
    end else if (pipe_commit_s) begin
      regwrite_d = 1'b1;
      rdaddr_d   = pipe_rd_i;
      rddata_d   = pipe_data_i;
    end else begin
      regwrite_d = 1'b0;
    end
    // Set after clear so a same-cycle re-issue keeps the bit.
    if (issue_i && (issue_rd_i != {`REG_NUM_BITS{1'b0}})) begin
      busy_d[issue_rd_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      starve_q   <= {STV_W{1'b0}};
      busy_q     <= 32'h0000_0000;
      regwrite_q <= 1'b0;
      rdaddr_q   <= {`REG_NUM_BITS{1'b0}};
      rddata_q   <= {`REG_LEN{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      busy_q     <= busy_d;
      regwrite_q <= regwrite_d;
      rdaddr_q   <= rdaddr_d;
      rddata_q   <= rddata_d;
    end
  end

  // FIFO slot write on accept
  always_ff @(posedge clk_i) begin
    if (accept_s) begin
      fifo_rd_q[wr_ptr_q]   <= lu_rd_i;
      fifo_data_q[wr_ptr_q] <= lu_data_i;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
`ifndef REG_NUM_BITS
`define REG_NUM_BITS 5
`endif
`ifndef REG_LEN
`define REG_LEN 32
`endif

module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        issue;
  logic [4:0]  issue_rd;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        regwrite;
  logic [4:0]  rdaddr;
  logic [31:0] rddata;
  logic [31:0] busy;

  int errors = 0;
  int checks = 0;

  writeback_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .pipe_we_i(pipe_we), .pipe_rd_i(pipe_rd), .pipe_data_i(pipe_data),
    .pipe_stall_o(pipe_stall),
    .issue_i(issue), .issue_rd_i(issue_rd),
    .lu_valid_i(lu_valid), .lu_ready_o(lu_ready),
    .lu_rd_i(lu_rd), .lu_data_i(lu_data),
    .RegWrite_o(regwrite), .RDaddr_o(rdaddr), .RDdata_o(rddata),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; pipe_we = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
    issue = 1'b0; issue_rd = 5'd0; lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'h44;   // discarded beat
    tick();
    idle();
    #1;
    checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got=%0b exp=0", regwrite); end
    checks++; if (rdaddr !== 5'd0) begin errors++; $display("FAIL reset_rdaddr got=%0d exp=0", rdaddr); end
    checks++; if (rddata !== 32'd0) begin errors++; $display("FAIL reset_rddata got=%h exp=0", rddata); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", lu_ready); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", pipe_stall); end
    tick();
    checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL reset_discard got=%0b exp=0", regwrite); end
  endtask

  task automatic test_pipe_write();
    idle();
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h11;
    tick();
    idle();
    checks++; if ({regwrite, rdaddr, rddata} !== {1'b1, 5'd5, 32'h11}) begin
      errors++; $display("FAIL pipe_write got=%0b/%0d/%h exp=1/5/11", regwrite, rdaddr, rddata); end
    tick();
    checks++; if ({regwrite, rdaddr, rddata} !== {1'b0, 5'd5, 32'h11}) begin
      errors++; $display("FAIL pipe_hold got=%0b/%0d/%h exp=0/5/11", regwrite, rdaddr, rddata); end
  endtask

  task automatic test_lu_write();
    idle();
    issue = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL lu_busy_set got=%h exp=00000080", busy); end
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'hAB;
    #1;
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL lu_ready got=%0b exp=1", lu_ready); end
    tick();
    idle();
    checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL lu_accept_cycle got=%0b exp=0", regwrite); end
    tick();
    checks++; if ({regwrite, rdaddr, rddata} !== {1'b1, 5'd7, 32'hAB}) begin
      errors++; $display("FAIL lu_commit got=%0b/%0d/%h exp=1/7/ab", regwrite, rdaddr, rddata); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL lu_busy_clear got=%h exp=0", busy); end
  endtask

  task automatic test_starve();
    idle();
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
    pipe_we = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h100;
    tick();
    checks++; if ({regwrite, rdaddr, rddata} !== {1'b1, 5'd1, 32'h100}) begin
      errors++; $display("FAIL starve_first got=%0b/%0d/%h exp=1/1/100", regwrite, rdaddr, rddata); end
    lu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pipe_rd = 5'(i + 2); pipe_data = 32'h200 + 32'(i);
      #1;
      checks++; if (pipe_stall !== (i == 3)) begin
        errors++; $display("FAIL starve_stall_%0d got=%0b exp=%0b", i, pipe_stall, (i == 3)); end
      tick();
      if (i < 3) begin
        checks++; if ({regwrite, rdaddr, rddata} !== {1'b1, 5'(i + 2), 32'h200 + 32'(i)}) begin
          errors++; $display("FAIL starve_pipe_%0d got=%0b/%0d/%h", i, regwrite, rdaddr, rddata); end
      end else begin
        checks++; if ({regwrite, rdaddr, rddata} !== {1'b1, 5'd9, 32'h99}) begin
          errors++; $display("FAIL starve_force got=%0b/%0d/%h exp=1/9/99", regwrite, rdaddr, rddata); end
      end
    end
    #1;
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_after got=%0b exp=0", pipe_stall); end
    tick();
    idle();
    checks++; if ({regwrite, rdaddr} !== {1'b1, 5'd5}) begin
      errors++; $display("FAIL starve_resume got=%0b/%0d exp=1/5", regwrite, rdaddr); end
  endtask

  task automatic test_full();
    idle();
    pipe_we = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
    lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'hA0;
    tick();
    lu_rd = 5'd11; lu_data = 32'hB0;
    tick();
    lu_rd = 5'd12; lu_data = 32'hC0;
    #1;
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b exp=0", lu_ready); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL full_stall got=%0b exp=0", pipe_stall); end
    tick();
    pipe_we = 1'b0;
    tick();
    checks++; if ({regwrite, rdaddr, rddata} !== {1'b1, 5'd10, 32'hA0}) begin
      errors++; $display("FAIL full_drain0 got=%0b/%0d/%h exp=1/10/a0", regwrite, rdaddr, rddata); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_again got=%0b exp=1", lu_ready); end
    tick();
    lu_valid = 1'b0;
    checks++; if ({regwrite, rdaddr, rddata} !== {1'b1, 5'd11, 32'hB0}) begin
      errors++; $display("FAIL full_drain1 got=%0b/%0d/%h exp=1/11/b0", regwrite, rdaddr, rddata); end
    tick();
    checks++; if ({regwrite, rdaddr, rddata} !== {1'b1, 5'd12, 32'hC0}) begin
      errors++; $display("FAIL full_drain2 got=%0b/%0d/%h exp=1/12/c0", regwrite, rdaddr, rddata); end
    tick();
    checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL full_empty got=%0b exp=0", regwrite); end
  endtask

  task automatic test_busy_collision();
    idle();
    issue = 1'b1; issue_rd = 5'd3;
    tick();
    idle();
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h33;
    tick();
    idle();
    issue = 1'b1; issue_rd = 5'd3;
    tick();
    idle();
    checks++; if ({regwrite, rdaddr} !== {1'b1, 5'd3}) begin
      errors++; $display("FAIL collide_commit got=%0b/%0d exp=1/3", regwrite, rdaddr); end
    checks++; if (busy !== 32'h0000_0008) begin errors++; $display("FAIL collide_busy got=%h exp=00000008", busy); end
  endtask

  task automatic test_x0();
    do_reset();
    pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h5;
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h6;
    issue = 1'b1; issue_rd = 5'd0;
    tick();
    idle();
    checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL x0_pipe got=%0b exp=0", regwrite); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL x0_busy got=%h exp=0", busy); end
    tick();
    checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL x0_lu got=%0b exp=0", regwrite); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL x0_busy2 got=%h exp=0", busy); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL x0_slot_freed got=%0b exp=1", lu_ready); end
    pipe_we = 1'b1; pipe_rd = 5'd2; pipe_data = 32'h22;
    tick();
    idle();
    checks++; if ({regwrite, rdaddr, rddata} !== {1'b1, 5'd2, 32'h22}) begin
      errors++; $display("FAIL x0_fifo_empty got=%0b/%0d/%h exp=1/2/22", regwrite, rdaddr, rddata); end
  endtask

  task automatic test_reset_mid_drain();
    idle();
    issue = 1'b1; issue_rd = 5'd13;
    pipe_we = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
    lu_valid = 1'b1; lu_rd = 5'd13; lu_data = 32'hD0;
    tick();
    issue = 1'b0;
    lu_rd = 5'd14; lu_data = 32'hE0;
    tick();
    pipe_we = 1'b0; lu_rd = 5'd15; lu_data = 32'hF0;
    rst = 1'b1;
    tick();
    idle();
    checks++; if ({regwrite, rdaddr, rddata} !== {1'b0, 5'd0, 32'd0}) begin
      errors++; $display("FAIL mid_rst_out got=%0b/%0d/%h exp=0/0/0", regwrite, rdaddr, rddata); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL mid_rst_busy got=%h exp=0", busy); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%0b exp=1", lu_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL mid_rst_nowrite_%0d got=%0b exp=0", i, regwrite); end
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    test_reset();
    test_pipe_write();
    test_lu_write();
    test_starve();
    test_full();
    test_busy_collision();
    test_x0();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
